// File: rtl/kernel_buffer_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : kernel_buffer_dispatcher
// Purpose  : Registered, valid/ready kernel-buffer to PE-row dispatcher.
//            Replicates a selected bank across each group of G rows, with a
//            latched configuration, auto bank sequencing, row valid mask and
//            a sticky illegal-select flag.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_buffer_dispatcher #(
  parameter int DEPTH = 2,
  parameter int D     = 1 << DEPTH,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [DEPTH-1:0] cfg_trc_i,
  input  logic             cfg_auto_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W*D-1:0]   in_data_i,
  input  logic [DEPTH-1:0] in_sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W*D-1:0]   out_data_o,
  output logic [D-1:0]     out_mask_o,
  output logic             out_last_o,
  output logic             err_sel_o
);

  // Configuration and sequencing state
  logic [DEPTH-1:0] trc_q, trc_d;
  logic             auto_q, auto_d;
  logic [DEPTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Output stage
  logic             out_valid_q, out_valid_d;
  logic [W*D-1:0]   out_data_q, out_data_d;
  logic [D-1:0]     out_mask_q, out_mask_d;
  logic             out_last_q, out_last_d;

  logic             w_cfg_load;
  logic             w_accept;
  logic [DEPTH-1:0] w_sel;
  logic             w_legal;

  logic [W-1:0]     w_bank      [D];
  logic [W-1:0]     w_cand_data [D][D];
  logic             w_cand_mask [D][D];

  // Config may only load into an empty pipeline and always wins over data.
  assign w_cfg_load = cfg_valid_i & ~out_valid_q;
  assign cfg_ready_o = ~out_valid_q;
  assign in_ready_o  = ~w_cfg_load & (~out_valid_q | out_ready_i);
  assign w_accept    = in_valid_i & in_ready_o;

  assign w_sel   = auto_q ? cnt_q : in_sel_i;
  assign w_legal = (w_sel <= trc_q);

  for (genvar b = 0; b < D; b++) begin : g_bank
    assign w_bank[b] = in_data_i[W*(b+1)-1 -: W];
  end

  // One candidate row mapping per group size; group geometry is fixed at
  // elaboration, so only an adder on the select is needed per row.
  for (genvar t = 0; t < D; t++) begin : g_grp
    localparam int GC  = t + 1;
    localparam int NGC = D / GC;
    for (genvar r = 0; r < D; r++) begin : g_row
      if (r < NGC * GC) begin : g_used
        localparam logic [DEPTH-1:0] BASE = DEPTH'((r / GC) * GC);
        logic [DEPTH-1:0] w_idx;
        assign w_idx             = BASE + w_sel;
        assign w_cand_data[t][r] = w_bank[w_idx];
        assign w_cand_mask[t][r] = 1'b1;
      end else begin : g_unused
        assign w_cand_data[t][r] = '0;
        assign w_cand_mask[t][r] = 1'b0;
      end
    end
  end

  // Next-state: config load, beat capture, counter advance and error latch.
  always_comb begin
    trc_d       = trc_q;
    auto_d      = auto_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;

    if (w_cfg_load) begin
      trc_d  = cfg_trc_i;
      auto_d = cfg_auto_i;
      cnt_d  = '0;
      err_d  = 1'b0;
    end

    if (w_accept) begin
      out_valid_d = 1'b1;
      out_last_d  = w_legal & (w_sel == trc_q);
      for (int r = 0; r < D; r++) begin
        out_data_d[W*r +: W] = w_legal ? w_cand_data[trc_q][r] : '0;
        out_mask_d[r]        = w_legal & w_cand_mask[trc_q][r];
      end
      if (!w_legal) begin
        err_d = 1'b1;
      end
      if (auto_q) begin
        cnt_d = (cnt_q == trc_q) ? '0 : cnt_q + DEPTH'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trc_q       <= '0;
      auto_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      trc_q       <= trc_d;
      auto_q      <= auto_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_last_o  = out_last_q;
  assign err_sel_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_buffer_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_kernel_buffer_dispatcher
// Purpose  : Directed self-checking bench for kernel_buffer_dispatcher
//            (D=4, W=16, banks A,B,C,D).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_buffer_dispatcher;

  localparam int DEPTH = 2;
  localparam int D     = 4;
  localparam int W     = 16;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DEPTH-1:0] cfg_trc;
  logic             cfg_auto;
  logic             in_valid;
  logic             in_ready;
  logic [W*D-1:0]   in_data;
  logic [DEPTH-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [W*D-1:0]   out_data;
  logic [D-1:0]     out_mask;
  logic             out_last;
  logic             err_sel;

  int n_checks = 0;
  int n_errors = 0;

  kernel_buffer_dispatcher #(.DEPTH(DEPTH), .D(D), .W(W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_trc_i   (cfg_trc),
    .cfg_auto_i  (cfg_auto),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_mask_o  (out_mask),
    .out_last_o  (out_last),
    .err_sel_o   (err_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] data,
                           input logic [3:0] mask, input logic last);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_data"},  out_data, data);
    check_val({tag, "_mask"},  64'(out_mask), 64'(mask));
    check_val({tag, "_last"},  64'(out_last), 64'(last));
  endtask

  task automatic load_cfg(input logic [1:0] trc, input logic auto_mode);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    check_val("cfg_ready_wait", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_trc   = trc;
    cfg_auto  = auto_mode;
    in_valid  = 1'b1;
    #1;
    check_val("cfg_priority_in_ready", 64'(in_ready), 64'd0);
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] sel);
    in_valid = 1'b1;
    in_sel   = sel;
    #1;
    check_val("beat_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bv;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_trc   = '0;
    cfg_auto  = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b1;
    in_data   = 64'h000D_000C_000B_000A;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data",  out_data, 64'd0);
    check_val("rst_out_mask",  64'(out_mask), 64'd0);
    check_val("rst_err_sel",   64'(err_sel), 64'd0);
    check_val("rst_cfg_ready", 64'(cfg_ready), 64'd1);

    // Pass-through
    load_cfg(2'd0, 1'b0);
    send_beat(2'd0);
    check_out("pass", 64'h000D_000C_000B_000A, 4'b1111, 1'b1);
    tick();
    check_val("pass_retire", 64'(out_valid), 64'd0);

    // Groups of two
    load_cfg(2'd1, 1'b0);
    send_beat(2'd1);
    check_out("grp2", 64'h000D_000D_000B_000B, 4'b1111, 1'b1);
    tick();

    // Groups of three with a remainder row
    load_cfg(2'd2, 1'b0);
    send_beat(2'd2);
    check_out("grp3", 64'h0000_000C_000C_000C, 4'b0111, 1'b1);
    tick();

    // Auto sweep, back-to-back beats
    load_cfg(2'd3, 1'b1);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bv = 16'h000A + 16'(k % 4);
      check_out($sformatf("auto%0d", k + 1), {bv, bv, bv, bv}, 4'b1111, k == 3);
    end

    // Backpressure: beat 5 (all A) must hold; a config request is blocked
    out_ready = 1'b0;
    cfg_valid = 1'b1;
    cfg_trc   = 2'd0;
    cfg_auto  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("stall_data",      out_data, 64'h000A_000A_000A_000A);
      check_val("stall_valid",     64'(out_valid), 64'd1);
      check_val("stall_in_ready",  64'(in_ready), 64'd0);
      check_val("stall_cfg_ready", 64'(cfg_ready), 64'd0);
    end
    // Release: old beat retires and next auto beat (B) loads on the same edge
    out_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check_out("after_stall", 64'h000B_000B_000B_000B, 4'b1111, 1'b0);
    tick();
    check_val("drain_valid", 64'(out_valid), 64'd0);
    check_val("pre_err",     64'(err_sel), 64'd0);

    // Illegal select in manual mode
    load_cfg(2'd1, 1'b0);
    send_beat(2'd3);
    check_out("illegal", 64'd0, 4'b0000, 1'b0);
    check_val("illegal_err", 64'(err_sel), 64'd1);
    tick();
    check_val("err_sticky_idle", 64'(err_sel), 64'd1);
    send_beat(2'd0);
    check_out("legal_after_err", 64'h000C_000C_000A_000A, 4'b1111, 1'b0);
    check_val("err_sticky_beat", 64'(err_sel), 64'd1);
    tick();
    load_cfg(2'd0, 1'b0);
    check_val("err_cleared_by_cfg", 64'(err_sel), 64'd0);

    // Asynchronous reset mid-stream drops the in-flight beat
    send_beat(2'd0);
    check_val("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", 64'(out_valid), 64'd0);
    check_val("async_rst_data",  out_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
